// File: rtl/multdiv_wb_ctrl_if.sv
// Write-port and mult/div handshake bundle between the pipeline and the write-back controller.
// No state; the pipeline side drives the master modport and the controller uses the slave modport.
// The controller's stall output is the pipeline's only backpressure.
interface multdiv_wb_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_we;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              md_start;
    logic              md_is_div;
    logic [ADDR_W-1:0] md_waddr;
    logic              md_result_rdy;
    logic [DATA_W-1:0] md_result;
    logic              md_exception;
    logic              stall;
    logic              md_busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output alu_we, alu_waddr, alu_wdata,
        output md_start, md_is_div, md_waddr,
        output md_result_rdy, md_result, md_exception,
        input  stall, md_busy, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  alu_we, alu_waddr, alu_wdata,
        input  md_start, md_is_div, md_waddr,
        input  md_result_rdy, md_result, md_exception,
        output stall, md_busy, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/multdiv_wb_ctrl.sv
// Register-file write-back arbiter: ALU pass-through, or a captured mult/div destination.
// Zero-latency write port; a mult/div result is written in the cycle md_result_rdy arrives.
// Stalls the pipeline from md_start until the mult/div completes, errors out or times out.
module multdiv_wb_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int MAX_CYCLES   = 40,
    parameter int RSTATUS_ADDR = 30
) (
    input  logic clock,
    input  logic reset,
    multdiv_wb_ctrl_if.slave wb
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [5:0]        CNT_LAST  = 6'(MAX_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STATUS_RA = ADDR_W'(RSTATUS_ADDR);
    localparam logic [DATA_W-1:0] CODE_MULT = DATA_W'(4);
    localparam logic [DATA_W-1:0] CODE_DIV  = DATA_W'(5);

    state_t            state;
    logic [ADDR_W-1:0] dest_q;
    logic              div_q;
    logic [5:0]        cnt_q;

    logic              done;
    logic              we_raw;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              stall_c;

    always_comb begin
        done    = 1'b0;
        we_raw  = 1'b0;
        waddr   = wb.alu_waddr;
        wdata   = wb.alu_wdata;
        stall_c = 1'b0;
        case (state)
            IDLE: begin
                if (wb.md_start) stall_c = 1'b1;
                else             we_raw  = wb.alu_we;
            end
            WAIT: begin
                waddr = dest_q;
                wdata = wb.md_result;
                if (wb.md_result_rdy || cnt_q == CNT_LAST) begin
                    done   = 1'b1;
                    we_raw = 1'b1;
                    // A timeout reports like an exception, with the same per-op code.
                    if (!wb.md_result_rdy || wb.md_exception) begin
                        waddr = STATUS_RA;
                        wdata = div_q ? CODE_DIV : CODE_MULT;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // r0 is hardwired; a write in the reset cycle would commit on the reset edge, so drop it.
    assign wb.rf_we    = we_raw && (waddr != '0) && !reset;
    assign wb.rf_waddr = waddr;
    assign wb.rf_wdata = wdata;
    assign wb.stall    = stall_c;
    assign wb.md_busy  = (state == WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            dest_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb.md_start) begin
                        dest_q <= wb.md_waddr;
                        div_q  <= wb.md_is_div;
                        cnt_q  <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) state <= IDLE;
                    else      cnt_q <= cnt_q + 6'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// Scoreboarded bench for multdiv_wb_ctrl: expected writes are queued as stimulus is driven
// and retired by a write-port monitor; scenario tasks also check stall/busy inline.
module tb_multdiv_wb_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int MAXC   = 40;
    localparam int RS     = 30;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    multdiv_wb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    multdiv_wb_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_CYCLES(MAXC), .RSTATUS_ADDR(RS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wb   (bus.slave)
    );

    always #5 clock = ~clock;

    // Every write-port commit must match the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({bus.rf_waddr, bus.rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_value got addr=%0d data=%h required addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        bus.alu_we        = 1'b0;
        bus.alu_waddr     = '0;
        bus.alu_wdata     = '0;
        bus.md_start      = 1'b0;
        bus.md_is_div     = 1'b0;
        bus.md_waddr      = '0;
        bus.md_result_rdy = 1'b0;
        bus.md_result     = '0;
        bus.md_exception  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet();
        cycle();
        cycle();
        @(negedge clock);
        checks++;
        if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0 || bus.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b stall=%b we=%b required 0 0 0",
                     bus.md_busy, bus.stall, bus.rf_we);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_pass();
        logic [ADDR_W-1:0] a [4] = '{5'd7, 5'd31, 5'd0, 5'd4};
        logic [DATA_W-1:0] d [4] = '{32'h1234, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h0BAD};
        logic              w [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cycle();
            quiet();
            bus.alu_we    = w[i];
            bus.alu_waddr = a[i];
            bus.alu_wdata = d[i];
            if (w[i] && a[i] != 0) exp_q.push_back('{a[i], d[i]});
            @(negedge clock);
            checks++;
            if (bus.rf_we !== (w[i] && a[i] != 0) || bus.stall !== 1'b0 ||
                (w[i] && (bus.rf_waddr !== a[i] || bus.rf_wdata !== d[i]))) begin
                errors++;
                $display("FAIL alu_pass[%0d] got we=%b addr=%0d data=%h stall=%b required we=%b addr=%0d data=%h stall=0",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall,
                         w[i] && a[i] != 0, a[i], d[i]);
            end
        end
        // A stray result pulse in IDLE must neither write nor start an op.
        cycle();
        quiet();
        bus.md_result_rdy = 1'b1;
        bus.md_result     = 32'h5555;
        cycle();
        quiet();
        @(negedge clock);
        checks++;
        if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_rdy_ignored got busy=%b stall=%b required 0 0", bus.md_busy, bus.stall);
        end
    endtask

    task automatic test_mult_complete();
        cycle();
        quiet();
        bus.md_start  = 1'b1;
        bus.md_waddr  = 5'd9;
        bus.alu_we    = 1'b1;
        bus.alu_waddr = 5'd12;
        bus.alu_wdata = 32'h1111;
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) begin
                cycle();
                quiet();
                if (c <= 16) begin
                    bus.alu_we    = 1'b1;
                    bus.alu_waddr = 5'd12;
                end
                if (c == 17) begin
                    bus.md_result_rdy = 1'b1;
                    bus.md_result     = 32'hDEAD;
                    exp_q.push_back('{5'd9, 32'hDEAD});
                end
            end
            @(negedge clock);
            if (c == 0 || c == 9 || c == 16) begin
                checks++;
                if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0) begin
                    errors++;
                    $display("FAIL mult_stall[c%0d] got stall=%b we=%b required 1 0", c, bus.stall, bus.rf_we);
                end
            end
            if (c == 17) begin
                checks++;
                if (bus.stall !== 1'b0 || bus.md_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL mult_done got stall=%b busy=%b required 0 1", bus.stall, bus.md_busy);
                end
            end
            if (c == 18) begin
                checks++;
                if (bus.md_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL mult_busy_clear got %b required 0", bus.md_busy);
                end
            end
        end
    endtask

    task automatic test_div_by_zero();
        cycle();
        quiet();
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b1;
        bus.md_waddr  = 5'd3;
        for (int c = 1; c <= 34; c++) begin
            cycle();
            quiet();
            if (c == 33) begin
                bus.md_result_rdy = 1'b1;
                bus.md_exception  = 1'b1;
                bus.md_result     = 32'h77;
                exp_q.push_back('{5'(RS), 32'd5});
            end
            @(negedge clock);
            if (c == 32 || c == 33) begin
                checks++;
                if (bus.stall !== (c == 32)) begin
                    errors++;
                    $display("FAIL div_stall[c%0d] got %b required %b", c, bus.stall, c == 32);
                end
            end
            if (c == 34) begin
                checks++;
                if (bus.md_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL div_busy_clear got %b required 0", bus.md_busy);
                end
            end
        end
    endtask

    task automatic test_timeout();
        cycle();
        quiet();
        bus.md_start = 1'b1;
        bus.md_waddr = 5'd17;
        for (int c = 1; c <= MAXC + 1; c++) begin
            cycle();
            quiet();
            if (c == MAXC) exp_q.push_back('{5'(RS), 32'd4});
            @(negedge clock);
            if (c == MAXC - 1 || c == MAXC) begin
                checks++;
                if (bus.stall !== (c == MAXC - 1) || bus.rf_we !== (c == MAXC)) begin
                    errors++;
                    $display("FAIL timeout[c%0d] got stall=%b we=%b required %b %b",
                             c, bus.stall, bus.rf_we, c == MAXC - 1, c == MAXC);
                end
            end
            if (c == MAXC + 1) begin
                checks++;
                if (bus.md_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_idle got busy=%b required 0", bus.md_busy);
                end
            end
        end
    endtask

    // Variant 0: dest r0 suppressed. 1: exception keeps original op type. 2: keeps original dest.
    task automatic test_masking();
        logic [ADDR_W-1:0] dst [3] = '{5'd0, 5'd5, 5'd5};
        for (int v = 0; v < 3; v++) begin
            cycle();
            quiet();
            bus.md_start  = 1'b1;
            bus.md_waddr  = dst[v];
            bus.alu_we    = 1'b1;
            bus.alu_waddr = 5'd8;
            @(negedge clock);
            checks++;
            if (bus.rf_we !== 1'b0 || bus.stall !== 1'b1) begin
                errors++;
                $display("FAIL start_mask[v%0d] got we=%b stall=%b required 0 1", v, bus.rf_we, bus.stall);
            end
            cycle();
            quiet();
            bus.md_start  = 1'b1;
            bus.md_is_div = 1'b1;
            bus.md_waddr  = 5'd11;
            bus.alu_we    = 1'b1;
            bus.alu_waddr = 5'd8;
            @(negedge clock);
            checks++;
            if (bus.rf_we !== 1'b0 || bus.stall !== 1'b1) begin
                errors++;
                $display("FAIL wait_mask[v%0d] got we=%b stall=%b required 0 1", v, bus.rf_we, bus.stall);
            end
            cycle();
            quiet();
            bus.md_result_rdy = 1'b1;
            bus.md_result     = 32'hC0DE_0000 + 32'(v);
            bus.md_exception  = (v == 1);
            if (v == 1) exp_q.push_back('{5'(RS), 32'd4});
            if (v == 2) exp_q.push_back('{5'd5, 32'hC0DE_0002});
            @(negedge clock);
            checks++;
            if (bus.rf_we !== (v != 0) || bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL mask_done[v%0d] got we=%b stall=%b required %b 0", v, bus.rf_we, bus.stall, v != 0);
            end
            cycle();
            quiet();
            @(negedge clock);
            checks++;
            if (bus.md_busy !== 1'b0) begin
                errors++;
                $display("FAIL mask_idle[v%0d] got busy=%b required 0", v, bus.md_busy);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        cycle();
        quiet();
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b1;
        bus.md_waddr  = 5'd6;
        for (int c = 1; c <= 5; c++) begin
            cycle();
            quiet();
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op got busy=%b stall=%b required 0 0", bus.md_busy, bus.stall);
        end
        cycle();
        bus.md_result_rdy = 1'b1;
        bus.md_result     = 32'hBEEF;
        @(negedge clock);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.md_busy !== 1'b0) begin
            errors++;
            $display("FAIL late_rdy got we=%b busy=%b required 0 0", bus.rf_we, bus.md_busy);
        end
        cycle();
        quiet();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] dst [2] = '{5'd9, 5'd10};
        for (int k = 0; k < 2; k++) begin
            cycle();
            quiet();
            bus.md_start  = 1'b1;
            bus.md_is_div = (k == 1);
            bus.md_waddr  = dst[k];
            cycle();
            quiet();
            bus.md_result_rdy = 1'b1;
            bus.md_result     = 32'h1000 + 32'(k);
            exp_q.push_back('{dst[k], 32'h1000 + 32'(k)});
            @(negedge clock);
            checks++;
            if (bus.rf_we !== 1'b1 || bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d] got we=%b stall=%b required 1 0", k, bus.rf_we, bus.stall);
            end
        end
        cycle();
        quiet();
        bus.alu_we    = 1'b1;
        bus.alu_waddr = 5'd2;
        bus.alu_wdata = 32'h2222;
        exp_q.push_back('{5'd2, 32'h2222});
        cycle();
        quiet();
    endtask

    initial begin
        quiet();
        test_reset();
        test_alu_pass();
        test_mult_complete();
        test_div_by_zero();
        test_timeout();
        test_masking();
        test_reset_mid_op();
        test_back_to_back();
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
